// File: rtl/avalon_led_pkg.sv
// Shared constants for the Avalon-MM LED/PWM controller:
// the word-address map seen over the lightweight bridge and the per-LED mode encoding.
package avalon_led_pkg;

  localparam logic [4:0] ADDR_DIRECT     = 5'h00;
  localparam logic [4:0] ADDR_MODE       = 5'h01;
  localparam logic [4:0] ADDR_PRESCALE   = 5'h02;
  localparam logic [4:0] ADDR_BLINK_MASK = 5'h03;
  localparam logic [4:0] ADDR_BLINK_PER  = 5'h04;
  localparam logic [4:0] ADDR_DUTY_BASE  = 5'h10;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_PWM    = 1'b1;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED lane: compares the shared PWM counter against this LED's duty,
// picks direct level or PWM by mode, and gates the result with the blink phase.
// Purely combinational; the top level registers the result onto the pin.
module led_pwm_channel
  import avalon_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                mode,
  input  logic                direct,
  input  logic                blink_mask,
  input  logic                phase,
  output logic                led_next
);

  logic pwm_on;
  logic src;

  // Duty compare, mode select and blink gating for this LED.
  always_comb begin
    pwm_on = (pwm_cnt < duty);
    src    = pwm_on;
    case (mode)
      MODE_DIRECT: src = direct;
      default:     src = pwm_on;
    endcase
    led_next = src & (~blink_mask | phase);
  end

endmodule

// File: rtl/avalon_led_pwm_ctrl.sv
// Avalon-MM slave LED controller: register file, PWM tick prescaler,
// shared PWM counter and blink timebase, plus one led_pwm_channel per LED.
module avalon_led_pwm_ctrl
  import avalon_led_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic [NUM_LEDS-1:0] leds
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [NUM_LEDS-1:0]   direct_reg;
  logic [NUM_LEDS-1:0]   mode_reg;
  logic [NUM_LEDS-1:0]   blink_mask_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [15:0]           blink_per_reg;
  logic [PWM_BITS-1:0]   duty_reg [NUM_LEDS];

  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [15:0]           blink_cnt;
  logic                  blink_phase;
  logic                  tick;
  logic                  period_end;

  logic [31:0]           read_mux;
  logic [NUM_LEDS-1:0]   led_next;

  // Only the low bits of the write bus are stored; the rest is deliberately dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // The >= compare lets a lowered PRESCALE fire at once instead of waiting for a wrap.
  assign tick       = (presc_cnt >= prescale_reg);
  assign period_end = tick && (pwm_cnt == PWM_MAX);

  // Register file: a write commits at the edge it is presented; unmapped addresses are ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      direct_reg     <= '0;
      mode_reg       <= '0;
      blink_mask_reg <= '0;
      prescale_reg   <= '0;
      blink_per_reg  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty_reg[i] <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_DIRECT:     direct_reg     <= avs_writedata[NUM_LEDS-1:0];
        ADDR_MODE:       mode_reg       <= avs_writedata[NUM_LEDS-1:0];
        ADDR_PRESCALE:   prescale_reg   <= avs_writedata[PRESCALE_W-1:0];
        ADDR_BLINK_MASK: blink_mask_reg <= avs_writedata[NUM_LEDS-1:0];
        ADDR_BLINK_PER:  blink_per_reg  <= avs_writedata[15:0];
        default: ;
      endcase
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (avs_address == ADDR_DUTY_BASE + 5'(i)) duty_reg[i] <= avs_writedata[PWM_BITS-1:0];
      end
    end
  end

  // Read-back mux with unused high bits and unmapped addresses returning zero.
  always_comb begin
    read_mux = '0;
    case (avs_address)
      ADDR_DIRECT:     read_mux[NUM_LEDS-1:0]   = direct_reg;
      ADDR_MODE:       read_mux[NUM_LEDS-1:0]   = mode_reg;
      ADDR_PRESCALE:   read_mux[PRESCALE_W-1:0] = prescale_reg;
      ADDR_BLINK_MASK: read_mux[NUM_LEDS-1:0]   = blink_mask_reg;
      ADDR_BLINK_PER:  read_mux[15:0]           = blink_per_reg;
      default: ;
    endcase
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (avs_address == ADDR_DUTY_BASE + 5'(i)) read_mux[PWM_BITS-1:0] = duty_reg[i];
    end
  end

  // Latency-1 read data that holds until the next read; a same-cycle write is not seen.
  always_ff @(posedge clk) begin
    if (!reset_n) avs_readdata <= '0;
    else if (avs_read) avs_readdata <= read_mux;
  end

  // Prescaler producing the PWM tick.
  always_ff @(posedge clk) begin
    if (!reset_n) presc_cnt <= '0;
    else if (tick) presc_cnt <= '0;
    else presc_cnt <= presc_cnt + 1'b1;
  end

  // Shared PWM counter, wrapping naturally at its full width.
  always_ff @(posedge clk) begin
    if (!reset_n) pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Blink timebase counted in PWM periods; a zero period parks the phase at "on".
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_per_reg == 16'd0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt >= blink_per_reg - 16'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .pwm_cnt   (pwm_cnt),
      .duty      (duty_reg[i]),
      .mode      (mode_reg[i]),
      .direct    (direct_reg[i]),
      .blink_mask(blink_mask_reg[i]),
      .phase     (blink_phase),
      .led_next  (led_next[i])
    );
  end

  // Registered LED drive so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (!reset_n) leds <= '0;
    else leds <= led_next;
  end

endmodule
